alu_uart_ctrl: RTL

- Sequencer that feeds the team's parameterised ALU from a byte-serial link (UART rx/tx cores) and returns results to the same link.
- Collects three bytes in order: operand A, operand B, opcode. Drives the ALU and captures the result and Zero flag.
- Transmits two bytes: the result byte, then a flag byte.
- Sits between the UART rx/tx cores and the ALU in the top-level board design.

---
 rtl/alu_uart_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_uart_ctrl.sv
// Byte-serial front end for the ALU: collects A, B and opcode from the UART rx core,
// runs one ALU cycle, then returns the result byte and the Zero-flag byte over the tx core.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAIT_A   | idle, waiting for operand A
// WAIT_B   | waiting for operand B (timeout armed)
// WAIT_OP  | waiting for opcode (timeout armed)
// EXEC     | operands stable at the ALU, result captured at end of cycle
// SEND_RES | request tx of result byte once tx core is free
// WAIT_RES | result byte shifting, wait for tx_done
// SEND_FLG | request tx of flag byte once tx core is free
// WAIT_FLG | flag byte shifting, wait for tx_done
module alu_uart_ctrl #(
    parameter int unsigned bits    = 8,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_done,
    input  logic            tx_busy,
    input  logic            tx_done,
    input  logic [bits-1:0] alu_result,
    input  logic            alu_zero,
    output logic [bits-1:0] alu_A,
    output logic [bits-1:0] alu_B,
    output logic [3:0]      alu_select,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    output logic            busy,
    output logic            timeout_err
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND_RES,
        WAIT_RES,
        SEND_FLG,
        WAIT_FLG
    } state_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LOAD = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state_q;
    logic [bits-1:0] alu_a_q;
    logic [bits-1:0] alu_b_q;
    logic [3:0]      alu_sel_q;
    logic [bits-1:0] res_q;
    logic            flg_q;
    logic [7:0]      tx_data_q;
    logic            busy_q;
    logic            timeout_err_q;
    logic [CW-1:0]   to_cnt_q;
    logic            send_state;
    logic            to_expire;

    assign send_state = (state_q == SEND_RES) || (state_q == SEND_FLG);
    // Down-counter reaches zero on the TIMEOUT-th silent cycle; a byte in that cycle wins.
    assign to_expire  = (TIMEOUT != 0) && (to_cnt_q == '0) && !rx_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= WAIT_A;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= '0;
            res_q         <= '0;
            flg_q         <= 1'b0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                WAIT_A: begin
                    if (rx_done) begin
                        alu_a_q  <= rx_data[bits-1:0];
                        busy_q   <= 1'b1;
                        to_cnt_q <= TO_LOAD;
                        state_q  <= WAIT_B;
                    end
                end
                WAIT_B, WAIT_OP: begin
                    if (rx_done) begin
                        to_cnt_q <= TO_LOAD;
                        if (state_q == WAIT_B) begin
                            alu_b_q <= rx_data[bits-1:0];
                            state_q <= WAIT_OP;
                        end else begin
                            alu_sel_q <= rx_data[3:0];
                            state_q   <= EXEC;
                        end
                    end else if (to_expire) begin
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= WAIT_A;
                    end else if (TIMEOUT != 0) begin
                        to_cnt_q <= to_cnt_q - CW'(1);
                    end
                end
                EXEC: begin
                    res_q     <= alu_result;
                    flg_q     <= alu_zero;
                    tx_data_q <= 8'(alu_result);
                    state_q   <= SEND_RES;
                end
                SEND_RES: begin
                    if (!tx_busy) state_q <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (tx_done) begin
                        tx_data_q <= {7'b0, flg_q};
                        state_q   <= SEND_FLG;
                    end
                end
                SEND_FLG: begin
                    if (!tx_busy) state_q <= WAIT_FLG;
                end
                WAIT_FLG: begin
                    if (tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= WAIT_A;
                    end
                end
                default: state_q <= WAIT_A;
            endcase
        end
    end

    // tx_start must react to tx_busy within the same cycle, so it is decoded from registered state.
    assign tx_start    = send_state && !tx_busy;
    assign alu_A       = alu_a_q;
    assign alu_B       = alu_b_q;
    assign alu_select  = alu_sel_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
